// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM states, datapath select codes and the decoded instruction classes.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_XOR  = 2'd2;
    localparam logic [1:0] ALU_SLT  = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_EXEC_BR = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        IC_LW, IC_SW, IC_J, IC_JAL, IC_BNE, IC_XORI, IC_ADDI,
        IC_ADD, IC_SUB, IC_SLT, IC_JR, IC_ILLEGAL
    } iclass_t;

    function automatic logic is_rtype_alu(iclass_t c);
        return (c == IC_ADD) || (c == IC_SUB) || (c == IC_SLT);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: opcode/funct to class enum plus
// an illegal flag for anything outside the supported subset.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic       illegal
);

    always_comb begin
        iclass = IC_ILLEGAL;
        case (opcode)
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            OP_J:    iclass = IC_J;
            OP_JAL:  iclass = IC_JAL;
            OP_BNE:  iclass = IC_BNE;
            OP_XORI: iclass = IC_XORI;
            OP_ADDI: iclass = IC_ADDI;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  iclass = IC_ADD;
                    FN_SUB:  iclass = IC_SUB;
                    FN_SLT:  iclass = IC_SLT;
                    FN_JR:   iclass = IC_JR;
                    default: iclass = IC_ILLEGAL;
                endcase
            end
            default: iclass = IC_ILLEGAL;
        endcase
        illegal = (iclass == IC_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the Lab3 MIPS CPU: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    output logic             ir_we,
    output logic             write_pc,
    output logic             is_branch,
    output logic             is_jump,
    output logic             is_jr,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             mem_we,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    iclass_t          iclass;
    logic             illegal;
    logic [CNT_W-1:0] count_q;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    instr_decode u_decode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .iclass (iclass),
        .illegal(illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            if (write_pc)
                count_q <= count_q + CNT_W'(1);
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    if (illegal)
                        state_q <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    else if (iclass == IC_J || iclass == IC_JAL || iclass == IC_JR)
                        state_q <= S_FETCH;
                    else if (iclass == IC_BNE)
                        state_q <= S_EXEC_BR;
                    else
                        state_q <= S_EXEC;
                end
                S_EXEC:    state_q <= (iclass == IC_LW || iclass == IC_SW) ? S_MEM : S_WB;
                S_EXEC_BR: state_q <= S_FETCH;
                S_MEM:     state_q <= (iclass == IC_SW) ? S_FETCH : S_WB;
                S_WB:      state_q <= S_FETCH;
                S_HALT:    state_q <= S_HALT;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_we     = 1'b0;
        write_pc  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_jr     = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = RD_RT;
        wb_sel    = WB_ALU;
        mem_we    = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: ir_we = 1'b1;
            S_DECODE: begin
                case (iclass)
                    IC_J: begin
                        write_pc = 1'b1;
                        is_jump  = 1'b1;
                    end
                    IC_JAL: begin
                        write_pc = 1'b1;
                        is_jump  = 1'b1;
                        reg_we   = 1'b1;
                        reg_dst  = RD_RA;
                        wb_sel   = WB_PC4;
                    end
                    IC_JR: begin
                        write_pc = 1'b1;
                        is_jr    = 1'b1;
                    end
                    IC_ILLEGAL: write_pc = !HALT_ON_ILLEGAL;
                    default: ;
                endcase
            end
            S_EXEC: begin
                alu_src = !is_rtype_alu(iclass);
                case (iclass)
                    IC_XORI: alu_op = ALU_XOR;
                    IC_SUB:  alu_op = ALU_SUB;
                    IC_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_BR: begin
                alu_op    = ALU_SUB;
                write_pc  = 1'b1;
                is_branch = ~alu_zero;
            end
            S_MEM: begin
                if (iclass == IC_SW) begin
                    mem_we   = 1'b1;
                    write_pc = 1'b1;
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                write_pc = 1'b1;
                reg_dst  = is_rtype_alu(iclass) ? RD_RD : RD_RT;
                wb_sel   = (iclass == IC_LW) ? WB_MEM : WB_ALU;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        // Reset suppresses every strobe so an abandoned instruction leaves no side effect.
        if (reset) begin
            ir_we    = 1'b0;
            write_pc = 1'b0;
            reg_we   = 1'b0;
            mem_we   = 1'b0;
        end
    end

    assign instr_done  = write_pc;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: per-instruction expected output
// sequences derived from the instruction-set rules, checked every cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic       ir_we, write_pc, is_branch, is_jump, is_jr, reg_we;
        logic [1:0] reg_dst, wb_sel;
        logic       mem_we, alu_src;
        logic [1:0] alu_op;
        logic [2:0] state;
        logic       instr_done, halted;
    } obs_t;

    logic        clk;
    logic        reset_v [2];
    logic [31:0] instr_v [2];
    logic        az_v    [2];
    obs_t        obs     [2];
    logic [31:0] cnt_obs [2];

    int   errors = 0;
    int   checks = 0;
    int   sel;
    logic chk_en;
    logic exp_rst;
    obs_t exp_obs;
    logic [31:0] exp_cnt;
    logic [31:0] model_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance 1 halts on illegal opcodes with a full counter; instance 0
    // retires them as NOPs with a 3-bit counter to exercise wrap-around.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned W = (g == 1) ? 32 : 3;
        logic ir_we, write_pc, is_branch, is_jump, is_jr, reg_we, mem_we, alu_src;
        logic instr_done, halted;
        logic [1:0] reg_dst, wb_sel, alu_op;
        logic [2:0] state;
        logic [W-1:0] cnt;

        multicycle_control #(.HALT_ON_ILLEGAL(g == 1), .CNT_W(W)) u_dut (
            .clk(clk), .reset(reset_v[g]), .instr(instr_v[g]), .alu_zero(az_v[g]),
            .ir_we(ir_we), .write_pc(write_pc), .is_branch(is_branch), .is_jump(is_jump),
            .is_jr(is_jr), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
            .mem_we(mem_we), .alu_src(alu_src), .alu_op(alu_op), .state(state),
            .instr_done(instr_done), .halted(halted), .instr_count(cnt)
        );

        assign obs[g] = {ir_we, write_pc, is_branch, is_jump, is_jr, reg_we, reg_dst, wb_sel,
                         mem_we, alu_src, alu_op, state, instr_done, halted};
        assign cnt_obs[g] = 32'(cnt);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'h00) return fn == 6'h20 || fn == 6'h22 || fn == 6'h2A || fn == 6'h08;
        return op == 6'h23 || op == 6'h2B || op == 6'h02 || op == 6'h03 ||
               op == 6'h05 || op == 6'h0E || op == 6'h08;
    endfunction

    // Number of cycles from FETCH to retire; a halting instruction is given
    // 2 cycles plus 20 cycles of observed HALT.
    function automatic int instr_len(input logic [31:0] ins, input bit hp);
        logic [5:0] op = ins[31:26];
        if (!legal(ins)) return hp ? 22 : 2;
        if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && ins[5:0] == 6'h08)) return 2;
        if (op == 6'h05) return 3;
        if (op == 6'h23) return 5;
        return 4;
    endfunction

    function automatic obs_t exp_at(input logic [31:0] ins, input logic az, input bit hp, input int k);
        obs_t o = '0;
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        bit isr = (op == 6'h00);
        bit ldst = (op == 6'h23 || op == 6'h2B);
        if (k == 0) begin
            o.state = 3'd0; o.ir_we = 1'b1;
        end else if (k == 1) begin
            o.state = 3'd1;
            if (!legal(ins)) begin
                o.write_pc = !hp;
            end else if (op == 6'h02 || op == 6'h03) begin
                o.write_pc = 1'b1; o.is_jump = 1'b1;
                if (op == 6'h03) begin
                    o.reg_we = 1'b1; o.reg_dst = 2'd2; o.wb_sel = 2'd2;
                end
            end else if (isr && fn == 6'h08) begin
                o.write_pc = 1'b1; o.is_jr = 1'b1;
            end
        end else if (!legal(ins)) begin
            o.state = 3'd6; o.halted = 1'b1;
        end else if (op == 6'h05) begin
            o.state = 3'd3; o.alu_op = 2'd1; o.write_pc = 1'b1; o.is_branch = !az;
        end else if (k == 2) begin
            o.state = 3'd2;
            o.alu_src = !isr;
            if (op == 6'h0E) o.alu_op = 2'd2;
            else if (isr && fn == 6'h22) o.alu_op = 2'd1;
            else if (isr && fn == 6'h2A) o.alu_op = 2'd3;
        end else if (k == 3 && ldst) begin
            o.state = 3'd4;
            if (op == 6'h2B) begin
                o.mem_we = 1'b1; o.write_pc = 1'b1;
            end
        end else begin
            o.state = 3'd5; o.reg_we = 1'b1; o.write_pc = 1'b1;
            o.reg_dst = isr ? 2'd1 : 2'd0;
            o.wb_sel = (op == 6'h23) ? 2'd1 : 2'd0;
        end
        o.instr_done = o.write_pc;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr(input bit allow_ill);
        logic [31:0] r = $urandom;
        int p = $urandom_range(allow_ill ? 13 : 10, 0);
        case (p)
            0: r[31:26] = 6'h23;
            1: r[31:26] = 6'h2B;
            2: r[31:26] = 6'h02;
            3: r[31:26] = 6'h03;
            4: r[31:26] = 6'h05;
            5: r[31:26] = 6'h0E;
            6: r[31:26] = 6'h08;
            7: begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
            8: begin r[31:26] = 6'h00; r[5:0] = 6'h22; end
            9: begin r[31:26] = 6'h00; r[5:0] = 6'h2A; end
            10: begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            11: r[31:26] = 6'h3F;
            12: r[31:26] = 6'h04;
            default: begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            obs_t a;
            a = obs[sel];
            if (exp_rst) begin
                check("reset_strobes", 32'({a.ir_we, a.write_pc, a.reg_we, a.mem_we, a.instr_done}), 32'd0);
                check("reset_state", 32'(a.state), 32'(exp_obs.state));
            end else begin
                check("outputs", 32'(a), 32'(exp_obs));
            end
            check("instr_count", cnt_obs[sel], exp_cnt);
        end
    end

    // Entered at posedge+1 with the DUT in FETCH; returns the same way.
    task automatic do_instr(input logic [31:0] ins, input logic az);
        bit hp = (sel == 1);
        int n = instr_len(ins, hp);
        instr_v[sel] = ins;
        az_v[sel] = az;
        for (int k = 0; k < n; k++) begin
            exp_obs = exp_at(ins, az, hp, k);
            chk_en = 1'b1;
            @(posedge clk); #1;
        end
        if (legal(ins) || !hp) begin
            model_cnt = (model_cnt + 1) & ((sel == 1) ? 32'hFFFF_FFFF : 32'h7);
            exp_cnt = model_cnt;
        end
    endtask

    task automatic do_reset(input logic [2:0] st_now);
        reset_v[sel] = 1'b1;
        exp_rst = 1'b1;
        exp_obs.state = st_now;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset_v[sel] = 1'b0;
        exp_rst = 1'b0;
        model_cnt = 0;
        exp_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_en = 1'b0; exp_rst = 1'b0; exp_obs = '0; exp_cnt = 0; model_cnt = 0;
        sel = 1;
        for (int i = 0; i < 2; i++) begin
            reset_v[i] = 1'b1; instr_v[i] = '0; az_v[i] = 1'b0;
        end
        @(posedge clk); #1;
        do_reset(3'd0);
        check("reset_state_lit", 32'(obs[1].state), 32'd0);

        do_instr(32'h2008_0005, 1'b0);
        check("addi_count_lit", cnt_obs[1], 32'd1);
        do_instr(32'h1509_FFFE, 1'b0);
        do_instr(32'h1509_FFFE, 1'b1);
        check("bne_count_lit", cnt_obs[1], 32'd3);
        do_instr(32'h0800_0004, 1'b0);
        do_instr(32'h0C00_0004, 1'b0);
        check("jump_count_lit", cnt_obs[1], 32'd5);
        do_instr(32'hAD09_0004, 1'b0);
        do_instr(32'h8D09_0004, 1'b0);
        check("mem_count_lit", cnt_obs[1], 32'd7);

        // Reset lands on the MEM cycle of a store.
        instr_v[1] = 32'hAD09_0004;
        for (int k = 0; k < 3; k++) begin
            exp_obs = exp_at(32'hAD09_0004, 1'b0, 1'b1, k);
            @(posedge clk); #1;
        end
        check("mem_state_before_reset", 32'(obs[1].state), 32'd4);
        do_reset(3'd4);
        check("post_reset_state_lit", 32'(obs[1].state), 32'd0);
        check("post_reset_count_lit", cnt_obs[1], 32'd0);

        for (int i = 0; i < 200; i++)
            do_instr(rand_instr(1'b0), 1'($urandom));

        do_instr(32'hFC00_0000, 1'b0);
        check("halted_lit", 32'(obs[1].halted), 32'd1);
        check("halt_state_lit", 32'(obs[1].state), 32'd6);
        do_reset(3'd6);
        check("halt_reset_state_lit", 32'(obs[1].state), 32'd0);

        chk_en = 1'b0;
        reset_v[1] = 1'b1;
        sel = 0;
        model_cnt = 0; exp_cnt = 0;
        do_reset(3'd0);
        do_instr(32'hFC00_0000, 1'b0);
        check("nop_illegal_count_lit", cnt_obs[0], 32'd1);
        for (int i = 0; i < 7; i++)
            do_instr(32'h0800_0004, 1'b0);
        check("wrap_count_lit", cnt_obs[0], 32'd0);
        for (int i = 0; i < 150; i++)
            do_instr(rand_instr(1'b1), 1'($urandom));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle control FSM that sequences the instruction-fetch unit, register file, ALU and data memory of the Lab3 MIPS CPU. It decodes the latched instruction register and drives, per state, the fetch-unit controls (write_pc, is_branch, is_jump), the register, memory and ALU enables, and mux selects. It also keeps a retired-instruction counter and halts on illegal opcodes.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an unknown opcode/funct enters HALT; 0: it retires as a NOP (PC+4).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high
instr  input  32  instruction register contents, valid from DECODE onward
alu_zero  input  1  ALU zero flag, sampled in EXEC_BR
ir_we  output  1  latch instruction-memory output into the IR
write_pc  output  1  fetch-unit PC update enable
is_branch  output  1  fetch-unit branch select
is_jump  output  1  fetch-unit jump select
is_jr  output  1  PC source is the rs register value (JR)
reg_we  output  1  register-file write enable
reg_dst  output  2  0=rt, 1=rd, 2=$ra(31)
wb_sel  output  2  0=ALU result, 1=memory data, 2=PC+4
mem_we  output  1  data-memory write enable
alu_src  output  1  0=rt, 1=sign-extended imm (zero-extended for XORI)
alu_op  output  2  0=ADD, 1=SUB, 2=XOR, 3=SLT
state  output  3  current FSM state, for debug
instr_done  output  1  one-cycle pulse on the cycle an instruction retires
halted  output  1  FSM is in HALT
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: on the clk edge with reset=1, state<=FETCH and instr_count<=0. While reset=1, every strobe (ir_we, write_pc, reg_we, mem_we, instr_done) is forced to 0 combinationally. Selects are don't-care.
- Reset mid-instruction abandons the instruction. No partial write occurs and the counter does not increment.
- All outputs except instr_count are Moore/Mealy decodes of state, the opcode and funct of instr, and alu_zero. Unlisted outputs are 0 in each state.
- Supported instructions: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, ADDI 0x08, and R-type (opcode 0x00) with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- FETCH(0): ir_we=1. Next state DECODE.
- DECODE(1):
  - J: write_pc=1, is_jump=1; go to FETCH.
  - JAL: as J plus reg_we=1, reg_dst=2, wb_sel=2; go to FETCH.
  - JR: write_pc=1, is_jr=1; go to FETCH.
  - BNE: go to EXEC_BR.
  - Other legal instructions: go to EXEC.
  - Illegal with HALT_ON_ILLEGAL=1: go to HALT.
  - Illegal with HALT_ON_ILLEGAL=0: write_pc=1; go to FETCH.
- EXEC(2):
  - LW/SW/ADDI: alu_src=1, alu_op=ADD.
  - XORI: alu_src=1, alu_op=XOR.
  - R-type: alu_src=0, alu_op per funct.
  - LW/SW go to MEM; all others go to WB.
- EXEC_BR(3): alu_src=0, alu_op=SUB, write_pc=1, is_branch=~alu_zero. Go to FETCH.
- MEM(4):
  - SW: mem_we=1, write_pc=1; go to FETCH.
  - LW: go to WB.
- WB(5): reg_we=1, write_pc=1.
  - reg_dst=1 for R-type, 0 otherwise.
  - wb_sel=1 for LW, 0 otherwise.
  - Go to FETCH.
- HALT(6): all strobes 0, halted=1. Only reset leaves HALT. Encoding 7 is unreachable and recovers to FETCH.
- Retire: instr_done = write_pc (outside reset). instr_count increments on the same edge; 2^CNT_W−1 wraps to 0.
- Cycle counts (FETCH through retire):
  - J/JAL/JR: 2.
  - BNE: 3.
  - SW, R-type, ADDI, XORI: 4.
  - LW: 5.
- write_pc is asserted exactly once per instruction. is_branch and is_jump are never both 1.

Decomposition:
- Package ctrl_pkg holds:
  - opcode and funct constants;
  - state encodings;
  - alu_op, reg_dst and wb_sel codes.
- One combinational sub-module, instr_decode, classifies instr into an instruction-class enum plus an illegal flag.
- multicycle_control holds the state register, next-state logic, output decode and counter.

Test Plan:
- ADDI 0x20080005 after reset:
  - states 0,1,2,5;
  - EXEC shows alu_src=1, alu_op=0;
  - WB shows reg_we=1, reg_dst=0, wb_sel=0, write_pc=1;
  - instr_count=1 after 4 cycles.
- BNE 0x1509FFFE, once with alu_zero=0 and once with alu_zero=1:
  - EXEC_BR shows write_pc=1, with is_branch=1 and 0 respectively;
  - 3 cycles each.
- J 0x08000004 then JAL 0x0C000004:
  - each retires in DECODE with is_jump=1 and write_pc=1;
  - JAL also shows reg_we=1, reg_dst=2, wb_sel=2;
  - instr_count=2.
- SW 0xAD090004 then LW 0x8D090004:
  - SW asserts mem_we=1 only in MEM and retires in 4 cycles;
  - LW has mem_we=0 throughout and retires in WB with wb_sel=1 after 5 cycles.
- Opcode 0x3F:
  - HALT_ON_ILLEGAL=1: halted=1, no write_pc for 20 cycles, then reset gives state=0;
  - HALT_ON_ILLEGAL=0: write_pc in DECODE, instr_count+1.
- Reset asserted during SW's MEM cycle:
  - mem_we=0 and write_pc=0 that cycle;
  - state=FETCH next cycle;
  - instr_count=0.
